clk_sel_ctrl: RTL

Control-domain sequencer that drives the one-hot clock-enable vector into the audio clock mux. It takes a binary clock-select request and runs a break-before-make sequence: deassert all enables, hold a guard interval, then assert the new enable. The guard interval lets the mux's per-clock synchronisers retire the old clock before the new one is gated on, so the mux never sees two enables high at once. Sits in the audio cortex between the register/config interface and the clock mux.

---
 rtl/clk_sel_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/clk_sel_ctrl.sv
// Break-before-make sequencer for the audio clock mux enables: drop all enables, hold a
// guard interval so the mux synchronisers retire the old clock, then enable the new one.
module clk_sel_ctrl #(
    parameter int unsigned P_NO_CLOCKS    = 4,
    parameter int unsigned P_SEL_W        = 2,
    parameter int unsigned P_GUARD_CYCLES = 8,
    parameter int unsigned P_DEFAULT_SEL  = 0
) (
    input  logic               clk_ir,
    input  logic               rst_il,
    input  logic               clk_sel_req_id,
    input  logic [P_SEL_W-1:0] clk_sel_id,
    output logic [P_NO_CLOCKS-1:0] clk_en_vec_od,
    output logic [P_SEL_W-1:0] clk_sel_cur_od,
    output logic               clk_sel_busy_od,
    output logic               clk_sel_ack_od,
    output logic               clk_sel_err_od
);

    localparam int unsigned CntW = $clog2(P_GUARD_CYCLES + 2);
    localparam logic [CntW-1:0] GuardLoad = CntW'(P_GUARD_CYCLES - 1);
    // Reset bring-up skips the OFF cycle and counts the release edge too, so it starts
    // two counts higher to land the first enable P_GUARD_CYCLES+1 cycles after release.
    localparam logic [CntW-1:0] ResetLoad = CntW'(P_GUARD_CYCLES + 1);
    localparam logic [P_SEL_W:0] NoClocks = P_NO_CLOCKS[P_SEL_W:0];
    localparam logic [P_SEL_W-1:0] DefaultSel = P_DEFAULT_SEL[P_SEL_W-1:0];

    typedef enum logic [1:0] {
        StIdle,
        StOff,
        StWait,
        StOn
    } state_e;

    state_e          state;
    logic [CntW-1:0] cnt;
    logic            req_init;

    function automatic logic [P_NO_CLOCKS-1:0] onehot(input logic [P_SEL_W-1:0] idx);
        logic [P_NO_CLOCKS-1:0] v;
        v = '0;
        for (int i = 0; i < P_NO_CLOCKS; i++) begin
            v[i] = (idx == i[P_SEL_W-1:0]);
        end
        return v;
    endfunction

    always_ff @(posedge clk_ir) begin
        if (!rst_il) begin
            state           <= StWait;
            cnt             <= ResetLoad;
            req_init        <= 1'b0;
            clk_en_vec_od   <= '0;
            clk_sel_cur_od  <= DefaultSel;
            clk_sel_busy_od <= 1'b1;
            clk_sel_ack_od  <= 1'b0;
            clk_sel_err_od  <= 1'b0;
        end else begin
            clk_sel_ack_od <= 1'b0;
            clk_sel_err_od <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (clk_sel_req_id) begin
                        if ({1'b0, clk_sel_id} >= NoClocks) begin
                            clk_sel_err_od <= 1'b1;
                        end else if (clk_sel_id == clk_sel_cur_od) begin
                            clk_sel_ack_od <= 1'b1;
                        end else begin
                            state           <= StOff;
                            req_init        <= 1'b1;
                            clk_en_vec_od   <= '0;
                            clk_sel_cur_od  <= clk_sel_id;
                            clk_sel_busy_od <= 1'b1;
                        end
                    end
                end
                StOff: begin
                    state <= StWait;
                    cnt   <= GuardLoad;
                end
                StWait: begin
                    if (cnt == '0) begin
                        state          <= StOn;
                        clk_en_vec_od  <= onehot(clk_sel_cur_od);
                        clk_sel_ack_od <= req_init;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                StOn: begin
                    state           <= StIdle;
                    clk_sel_busy_od <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
